fetch_pc_ras: RTL and testbench

//  Next-generation program counter for the IF stage: parametrised address width.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/ras_stack.sv | 58 +++++
 rtl/fetch_pc_ras.sv | 95 +++++++++
 tb/tb_fetch_pc_ras.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the IF-stage program counter: next-PC source select and its
// priority decode.
package fetch_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_CALL   = 3'd3,
        PC_RET    = 3'd4
    } pc_sel_e;

    // halt and stall both freeze everything; halt additionally drives halted.
    function automatic pc_sel_e next_sel(input logic halt, input logic stall,
                                         input logic ret, input logic call,
                                         input logic br_taken);
        if (halt || stall) return PC_HOLD;
        if (ret)           return PC_RET;
        if (call)          return PC_CALL;
        if (br_taken)      return PC_BRANCH;
        return PC_INC;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular storage with a saturating count, so a push
// while full silently replaces the oldest entry.
module ras_stack #(
    parameter int A         = 8,
    parameter int RAS_DEPTH = 4,
    localparam int PW       = $clog2(RAS_DEPTH),
    localparam int CW       = $clog2(RAS_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [A-1:0]  push_data_i,
    output logic [A-1:0]  top_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [A-1:0]  mem_q [RAS_DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] sp_m1;

    // sp_q is the next write slot; when full it also points at the oldest entry.
    assign sp_m1   = sp_q - PW'(1);
    assign top_o   = mem_q[sp_m1];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            sp_d = sp_q + PW'(1);
            if (!full_o) cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d  = sp_m1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_i) mem_q[sp_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_pc_ras.sv
// IF-stage program counter with absolute/relative branches, call/return via
// a return-address stack, halt/stall freezing and sticky RAS error flags.
module fetch_pc_ras
    import fetch_pkg::*;
#(
    parameter int A         = 8,
    parameter int RAS_DEPTH = 4,
    localparam int CW       = $clog2(RAS_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [A-1:0]  inst_addr_reset,
    input  logic          halt,
    input  logic          stall,
    input  logic          ctrl_branch,
    input  logic          take_branch,
    input  logic          branch_rel,
    input  logic [A-1:0]  branch_target,
    input  logic          ctrl_call,
    input  logic          ctrl_ret,
    output logic [A-1:0]  inst_addr_out,
    output logic [CW-1:0] ras_count,
    output logic          ras_overflow,
    output logic          ras_underflow,
    output logic          halted
);

    pc_sel_e      sel;
    logic [A-1:0] pc_q, pc_d, pc_inc, target, ras_top;
    logic         ovf_q, ovf_d, unf_q, unf_d, halted_q;
    logic         ras_full, ras_empty, push, pop;

    assign sel    = next_sel(halt, stall, ctrl_ret, ctrl_call, ctrl_branch && take_branch);
    assign pc_inc = pc_q + A'(1);
    assign target = branch_rel ? pc_q + branch_target : branch_target;
    assign push   = (sel == PC_CALL);
    assign pop    = (sel == PC_RET);

    ras_stack #(.A(A), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        unique case (sel)
            PC_HOLD:   pc_d = pc_q;
            PC_INC:    pc_d = pc_inc;
            PC_BRANCH: pc_d = target;
            PC_CALL: begin
                pc_d = target;
                if (ras_full) ovf_d = 1'b1;
            end
            PC_RET: begin
                // An empty return falls through to the next instruction.
                if (ras_empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d = ras_top;
                end
            end
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= inst_addr_reset;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halted_q <= halt;
        end
    end

    assign inst_addr_out = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_pc_ras.sv
// Directed bench for fetch_pc_ras (A=8, RAS_DEPTH=4) with hand-computed PCs.
module tb_fetch_pc_ras;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] inst_addr_reset;
    logic       halt, stall, ctrl_branch, take_branch, branch_rel, ctrl_call, ctrl_ret;
    logic [7:0] branch_target;
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       ovf, unf, hltd;

    int checks   = 0;
    int failures = 0;

    fetch_pc_ras #(.A(8), .RAS_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_addr_reset (inst_addr_reset),
        .halt            (halt),
        .stall           (stall),
        .ctrl_branch     (ctrl_branch),
        .take_branch     (take_branch),
        .branch_rel      (branch_rel),
        .branch_target   (branch_target),
        .ctrl_call       (ctrl_call),
        .ctrl_ret        (ctrl_ret),
        .inst_addr_out   (pc),
        .ras_count       (cnt),
        .ras_overflow    (ovf),
        .ras_underflow   (unf),
        .halted          (hltd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        halt = 0; stall = 0; ctrl_branch = 0; take_branch = 0; branch_rel = 0;
        branch_target = 8'h00; ctrl_call = 0; ctrl_ret = 0;
    endtask

    task automatic do_reset(input logic [7:0] addr);
        idle();
        reset = 0; inst_addr_reset = addr;
        tick();
        reset = 1;
    endtask

    task automatic call_abs(input logic [7:0] t);
        idle(); ctrl_call = 1; branch_target = t;
        tick();
    endtask

    task automatic ret();
        idle(); ctrl_ret = 1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 0; inst_addr_reset = 8'h10;
        tick();
        checks++; if (pc !== 8'h10) begin failures++; $display("FAIL reset_pc got=%h exp=10", pc); end
        checks++; if ({cnt, ovf, unf, hltd} !== 6'b000_000) begin
            failures++; $display("FAIL reset_state got cnt=%0d ovf=%b unf=%b halted=%b exp 0", cnt, ovf, unf, hltd); end
        reset = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 8'h10 + 8'(i)) begin
                failures++; $display("FAIL reset_inc%0d got=%h exp=%h", i, pc, 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_wrap_rel();
        do_reset(8'hFE);
        ctrl_branch = 1; take_branch = 1; branch_rel = 1; branch_target = 8'h03;
        tick();
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL rel_wrap got=%h exp=01", pc); end
        branch_target = 8'hFE;  // -2
        tick();
        checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL rel_neg got=%h exp=FF", pc); end
        idle();
        tick();
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL inc_wrap got=%h exp=00", pc); end
        ctrl_branch = 1; take_branch = 0; branch_target = 8'h77;
        tick();
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL not_taken got=%h exp=01", pc); end
        take_branch = 1;
        tick();
        checks++; if (pc !== 8'h77) begin failures++; $display("FAIL abs_taken got=%h exp=77", pc); end
    endtask

    task automatic test_call_ret();
        do_reset(8'h20);
        call_abs(8'h40);
        checks++; if (pc !== 8'h40 || cnt !== 3'd1) begin
            failures++; $display("FAIL call1 got pc=%h cnt=%0d exp pc=40 cnt=1", pc, cnt); end
        call_abs(8'h60);
        checks++; if (pc !== 8'h60 || cnt !== 3'd2) begin
            failures++; $display("FAIL call2 got pc=%h cnt=%0d exp pc=60 cnt=2", pc, cnt); end
        ret();
        checks++; if (pc !== 8'h41 || cnt !== 3'd1) begin
            failures++; $display("FAIL ret1 got pc=%h cnt=%0d exp pc=41 cnt=1", pc, cnt); end
        ret();
        checks++; if (pc !== 8'h21 || cnt !== 3'd0 || unf !== 1'b0) begin
            failures++; $display("FAIL ret2 got pc=%h cnt=%0d unf=%b exp pc=21 cnt=0 unf=0", pc, cnt, unf); end
        // relative call from 21 with +0x10 -> 31, push 22
        idle(); ctrl_call = 1; branch_rel = 1; branch_target = 8'h10;
        tick();
        checks++; if (pc !== 8'h31 || cnt !== 3'd1) begin
            failures++; $display("FAIL call_rel got pc=%h cnt=%0d exp pc=31 cnt=1", pc, cnt); end
        // call+ret together: ret wins, no push
        idle(); ctrl_call = 1; ctrl_ret = 1; branch_target = 8'h99;
        tick();
        checks++; if (pc !== 8'h22 || cnt !== 3'd0) begin
            failures++; $display("FAIL call_and_ret got pc=%h cnt=%0d exp pc=22 cnt=0", pc, cnt); end
    endtask

    task automatic test_ras_limits();
        logic [7:0] exp_ret [4];
        exp_ret[0] = 8'h41; exp_ret[1] = 8'h31; exp_ret[2] = 8'h21; exp_ret[3] = 8'h11;
        do_reset(8'h00);
        for (int i = 1; i <= 4; i++) call_abs(8'(i * 16));
        checks++; if (ovf !== 1'b0 || cnt !== 3'd4) begin
            failures++; $display("FAIL ras_full got ovf=%b cnt=%0d exp ovf=0 cnt=4", ovf, cnt); end
        call_abs(8'h50);
        checks++; if (ovf !== 1'b1 || cnt !== 3'd4 || pc !== 8'h50) begin
            failures++; $display("FAIL ras_ovf got ovf=%b cnt=%0d pc=%h exp 1/4/50", ovf, cnt, pc); end
        for (int i = 0; i < 4; i++) begin
            ret();
            checks++; if (pc !== exp_ret[i] || cnt !== 3'(3 - i)) begin
                failures++; $display("FAIL lifo%0d got pc=%h cnt=%0d exp pc=%h cnt=%0d", i, pc, cnt, exp_ret[i], 3 - i); end
        end
        ret();
        checks++; if (pc !== 8'h12 || cnt !== 3'd0 || unf !== 1'b1 || ovf !== 1'b1) begin
            failures++; $display("FAIL ras_unf got pc=%h cnt=%0d unf=%b ovf=%b exp 12/0/1/1", pc, cnt, unf, ovf); end
    endtask

    task automatic test_freeze();
        do_reset(8'h30);
        call_abs(8'h50);
        idle(); halt = 1; ctrl_branch = 1; take_branch = 1; branch_target = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 8'h50 || cnt !== 3'd1 || hltd !== 1'b1) begin
                failures++; $display("FAIL halt%0d got pc=%h cnt=%0d halted=%b exp 50/1/1", i, pc, cnt, hltd); end
        end
        halt = 0;
        tick();
        checks++; if (pc !== 8'h80 || hltd !== 1'b0) begin
            failures++; $display("FAIL halt_release got pc=%h halted=%b exp 80/0", pc, hltd); end
        stall = 1; branch_target = 8'h90;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 8'h80 || cnt !== 3'd1 || hltd !== 1'b0) begin
                failures++; $display("FAIL stall%0d got pc=%h cnt=%0d halted=%b exp 80/1/0", i, pc, cnt, hltd); end
        end
        stall = 0;
        tick();
        checks++; if (pc !== 8'h90) begin failures++; $display("FAIL stall_release got=%h exp=90", pc); end
        idle(); stall = 1; ctrl_ret = 1;
        tick();
        checks++; if (pc !== 8'h90 || cnt !== 3'd1 || unf !== 1'b0) begin
            failures++; $display("FAIL stall_ret got pc=%h cnt=%0d unf=%b exp 90/1/0", pc, cnt, unf); end
        stall = 0;
        tick();
        checks++; if (pc !== 8'h31 || cnt !== 3'd0) begin
            failures++; $display("FAIL ret_after_stall got pc=%h cnt=%0d exp 31/0", pc, cnt); end
    endtask

    task automatic test_midop_reset();
        do_reset(8'h00);
        call_abs(8'h10);
        call_abs(8'h20);
        idle(); ctrl_ret = 1; reset = 0; inst_addr_reset = 8'hA0;
        tick();
        checks++; if (pc !== 8'hA0 || cnt !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
            failures++; $display("FAIL midop_reset got pc=%h cnt=%0d ovf=%b unf=%b exp A0/0/0/0", pc, cnt, ovf, unf); end
        reset = 1;
        tick();
        checks++; if (pc !== 8'hA1 || cnt !== 3'd0 || unf !== 1'b1) begin
            failures++; $display("FAIL ret_after_reset got pc=%h cnt=%0d unf=%b exp A1/0/1", pc, cnt, unf); end
    endtask

    initial begin
        reset = 0; inst_addr_reset = 8'h00;
        idle();
        test_reset();
        test_wrap_rel();
        test_call_ret();
        test_ras_limits();
        test_freeze();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
